note_player: RTL and testbench

Single-voice note timing stage directly downstream of `song_reader`. There are three instances, one per voice. Each instance:

- accepts a `{note, duration}` load from `song_reader`;
- converts the note number to a phase-increment step size for the sine sample generator;
- holds the step for the requested number of beats;
- reports through `note_done` that the voice is free.

`song_reader` consumes `note_done` as the `note_one_done`/`note_two_done`/`note_three_done` inputs it uses for voice allocation.

---
 rtl/note_player_pkg.sv | 17 +
 rtl/frequency_rom.sv | 87 ++++++++
 rtl/note_player.sv | 112 +++++++++++
 tb/tb_note_player.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_player_pkg.sv
// Shared widths and FSM state encodings for the per-voice note timing stage.
// Imported by note_player and frequency_rom.
package note_player_pkg;

  localparam int NOTE_WIDTH     = 6;
  localparam int DURATION_WIDTH = 6;
  localparam int ROM_WIDTH      = 20;
  localparam int STEP_WIDTH_DEF = ROM_WIDTH;
  localparam int STATE_WIDTH    = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    PLAYING = 2'd2
  } state_e;

endpackage

// File: rtl/frequency_rom.sv
// Note number to phase-increment ROM: round(27.5*2^((n-1)/12) * 2^20 / 48000).
// Synchronous read, one cycle of latency; entry 0 (rest) is zero.
module frequency_rom
  import note_player_pkg::*;
(
  input  logic                  clk,
  input  logic [NOTE_WIDTH-1:0] addr,
  output logic [ROM_WIDTH-1:0]  data_q
);

  logic [ROM_WIDTH-1:0] data_d;

  always_comb begin
    data_d = '0;
    case (addr)
      6'd1:  data_d = 20'd601;
      6'd2:  data_d = 20'd636;
      6'd3:  data_d = 20'd674;
      6'd4:  data_d = 20'd714;
      6'd5:  data_d = 20'd757;
      6'd6:  data_d = 20'd802;
      6'd7:  data_d = 20'd850;
      6'd8:  data_d = 20'd900;
      6'd9:  data_d = 20'd954;
      6'd10: data_d = 20'd1010;
      6'd11: data_d = 20'd1070;
      6'd12: data_d = 20'd1134;
      6'd13: data_d = 20'd1201;
      6'd14: data_d = 20'd1273;
      6'd15: data_d = 20'd1349;
      6'd16: data_d = 20'd1429;
      6'd17: data_d = 20'd1514;
      6'd18: data_d = 20'd1604;
      6'd19: data_d = 20'd1699;
      6'd20: data_d = 20'd1800;
      6'd21: data_d = 20'd1907;
      6'd22: data_d = 20'd2021;
      6'd23: data_d = 20'd2141;
      6'd24: data_d = 20'd2268;
      6'd25: data_d = 20'd2403;
      6'd26: data_d = 20'd2546;
      6'd27: data_d = 20'd2697;
      6'd28: data_d = 20'd2858;
      6'd29: data_d = 20'd3028;
      6'd30: data_d = 20'd3208;
      6'd31: data_d = 20'd3398;
      6'd32: data_d = 20'd3600;
      6'd33: data_d = 20'd3815;
      6'd34: data_d = 20'd4041;
      6'd35: data_d = 20'd4282;
      6'd36: data_d = 20'd4536;
      6'd37: data_d = 20'd4806;
      6'd38: data_d = 20'd5092;
      6'd39: data_d = 20'd5395;
      6'd40: data_d = 20'd5715;
      6'd41: data_d = 20'd6055;
      6'd42: data_d = 20'd6415;
      6'd43: data_d = 20'd6797;
      6'd44: data_d = 20'd7201;
      6'd45: data_d = 20'd7629;
      6'd46: data_d = 20'd8083;
      6'd47: data_d = 20'd8563;
      6'd48: data_d = 20'd9072;
      6'd49: data_d = 20'd9612;
      6'd50: data_d = 20'd10184;
      6'd51: data_d = 20'd10789;
      6'd52: data_d = 20'd11431;
      6'd53: data_d = 20'd12110;
      6'd54: data_d = 20'd12830;
      6'd55: data_d = 20'd13593;
      6'd56: data_d = 20'd14402;
      6'd57: data_d = 20'd15258;
      6'd58: data_d = 20'd16165;
      6'd59: data_d = 20'd17127;
      6'd60: data_d = 20'd18145;
      6'd61: data_d = 20'd19224;
      6'd62: data_d = 20'd20367;
      6'd63: data_d = 20'd21578;
      default: data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

endmodule

// File: rtl/note_player.sv
// Single-voice note timing stage: latches {note, duration}, looks up the step,
// holds it for the requested beats. NOTE_PLAYER_GAP_EN mutes the last beat.
//
// state   | meaning
// IDLE    | voice free, note_done high, silent
// LOOKUP  | ROM read cycle for the latched note
// PLAYING | step held until the beat count runs out
module note_player
  import note_player_pkg::*;
#(
  parameter int STEP_WIDTH = STEP_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play_enable,
  input  logic [NOTE_WIDTH-1:0]     note_to_load,
  input  logic [DURATION_WIDTH-1:0] duration_to_load,
  input  logic                      load_new_note,
  input  logic                      beat,
  output logic [STEP_WIDTH-1:0]     step_size,
  output logic                      note_done
);

  state_e                    state_q, state_d;
  logic [DURATION_WIDTH-1:0] beat_count_q, beat_count_d;
  logic [DURATION_WIDTH-1:0] duration_q, duration_d;
  logic [NOTE_WIDTH-1:0]     note_q, note_d;
  logic [ROM_WIDTH-1:0]      rom_data;
  logic                      beat_hit;
  logic                      count_zero;
  logic                      gap_mute;

  frequency_rom u_frequency_rom (
    .clk    (clk),
    .addr   (note_q),
    .data_q (rom_data)
  );

  assign beat_hit   = play_enable && beat;
  assign count_zero = (beat_count_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      beat_count_q <= '0;
      duration_q   <= '0;
      note_q       <= '0;
    end else begin
      state_q      <= state_d;
      beat_count_q <= beat_count_d;
      duration_q   <= duration_d;
      note_q       <= note_d;
    end
  end

  // A load wins over everything, including a beat in the same cycle.
  always_comb begin
    state_d      = state_q;
    beat_count_d = beat_count_q;
    duration_d   = duration_q;
    note_d       = note_q;
    if (load_new_note) begin
      state_d      = LOOKUP;
      beat_count_d = duration_to_load;
      duration_d   = duration_to_load;
      note_d       = note_to_load;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        LOOKUP: begin
          state_d = PLAYING;
          if (beat_hit && !count_zero) begin
            beat_count_d = beat_count_q - DURATION_WIDTH'(1);
          end
        end
        PLAYING: begin
          if (count_zero) begin
            state_d = IDLE;
          end else if (beat_hit) begin
            beat_count_d = beat_count_q - DURATION_WIDTH'(1);
            if (beat_count_q == DURATION_WIDTH'(1)) begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

`ifdef NOTE_PLAYER_GAP_EN
  assign gap_mute = (beat_count_q == DURATION_WIDTH'(1)) &&
                    (duration_q >= DURATION_WIDTH'(2));
`else
  assign gap_mute = 1'b0;
`endif

  always_comb begin
    step_size = '0;
    if ((state_q == PLAYING) && play_enable && (note_q != '0) &&
        !count_zero && !gap_mute) begin
      step_size = STEP_WIDTH'(rom_data);
    end
  end

  assign note_done = (state_q == IDLE);

endmodule

// File: tb/tb_note_player.sv
// Self-checking bench for note_player: directed test-plan scenarios plus random
// stimulus, checked every cycle against a beat-level behavioural model.
module tb_note_player;

  logic        clk;
  logic        reset;
  logic        play_enable;
  logic [5:0]  note_to_load;
  logic [5:0]  duration_to_load;
  logic        load_new_note;
  logic        beat;
  logic [19:0] step_size;
  logic        note_done;

  int n_checks;
  int n_fail;

  note_player dut (
    .clk              (clk),
    .reset            (reset),
    .play_enable      (play_enable),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .load_new_note    (load_new_note),
    .beat             (beat),
    .step_size        (step_size),
    .note_done        (note_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [19:0] ref_step(input int n);
    real f;
    if (n == 0) return 20'd0;
    f = 27.5 * $pow(2.0, (n - 1) / 12.0);
    return 20'($rtoi(f * 1048576.0 / 48000.0 + 0.5));
  endfunction

  // Model: a busy voice, edges since its load (age), beats still owed.
  bit m_valid;
  bit m_busy;
  int m_age;
  int m_rem;
  int m_note;
  int m_dur;

  initial begin
    m_valid = 0;
    m_busy  = 0;
    m_age   = 0;
    m_rem   = 0;
    m_note  = 0;
    m_dur   = 0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_valid = 1;
      m_busy  = 0;
      m_rem   = 0;
    end else if (load_new_note) begin
      m_busy = 1;
      m_age  = 0;
      m_rem  = duration_to_load;
      m_note = note_to_load;
      m_dur  = duration_to_load;
    end else if (m_busy) begin
      if (m_age == 0) begin
        if (play_enable && beat && m_rem > 0) m_rem--;
        m_age = 1;
      end else if (m_rem == 0) begin
        m_busy = 0;
      end else if (play_enable && beat) begin
        m_rem--;
        if (m_rem == 0) m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [19:0] exp_step;
    bit gap;
    if (m_valid) begin
      gap = 0;
`ifdef NOTE_PLAYER_GAP_EN
      gap = (m_rem == 1) && (m_dur >= 2);
`endif
      exp_step = 20'd0;
      if (m_busy && m_age >= 1 && play_enable && m_rem > 0 && !gap)
        exp_step = ref_step(m_note);
      check("model_note_done", {31'd0, note_done}, {31'd0, !m_busy});
      check("model_step_size", {12'd0, step_size}, {12'd0, exp_step});
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    cyc(1);
    beat = 1'b0;
  endtask

  task automatic load(input int note, input int dur);
    note_to_load     = 6'(note);
    duration_to_load = 6'(dur);
    load_new_note    = 1'b1;
    cyc(1);
    load_new_note    = 1'b0;
  endtask

  initial begin
    int k;
    n_checks         = 0;
    n_fail           = 0;
    reset            = 1'b1;
    play_enable      = 1'b0;
    note_to_load     = '0;
    duration_to_load = '0;
    load_new_note    = 1'b0;
    beat             = 1'b0;

    check("ref_rom49", {12'd0, ref_step(49)}, 32'h0258C);
    check("ref_rom10", {12'd0, ref_step(10)}, 32'd1010);
    check("ref_rom1",  {12'd0, ref_step(1)},  32'd601);

    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("reset_done", {31'd0, note_done}, 32'd1);
    check("reset_step", {12'd0, step_size}, 32'd0);
    play_enable = 1'b1;
    repeat (3) begin pulse_beat(); cyc(1); end
    check("idle_beats_done", {31'd0, note_done}, 32'd1);

    // note 49, 3 beats
    load(49, 3);
    check("a4_busy", {31'd0, note_done}, 32'd0);
    cyc(1);
    check("a4_step", {12'd0, step_size}, 32'h0258C);
    pulse_beat(); cyc(1);
    pulse_beat(); cyc(1);
    check("a4_busy2", {31'd0, note_done}, 32'd0);
    pulse_beat();
    check("a4_done", {31'd0, note_done}, 32'd1);
    check("a4_silent", {12'd0, step_size}, 32'd0);

    // pause and resume
    load(49, 2);
    cyc(1);
    pulse_beat(); cyc(1);
    play_enable = 1'b0;
    repeat (5) begin pulse_beat(); cyc(1); end
    check("pause_step", {12'd0, step_size}, 32'd0);
    check("pause_busy", {31'd0, note_done}, 32'd0);
    play_enable = 1'b1;
    cyc(1);
    check("resume_step", {12'd0, step_size}, 32'h0258C);
    pulse_beat();
    check("resume_end", {31'd0, note_done}, 32'd1);

    // rest, 2 beats
    load(0, 2);
    cyc(1);
    check("rest_step", {12'd0, step_size}, 32'd0);
    pulse_beat(); cyc(1);
    check("rest_busy", {31'd0, note_done}, 32'd0);
    pulse_beat();
    check("rest_done", {31'd0, note_done}, 32'd1);

    // preempt with simultaneous beat
    load(49, 5);
    cyc(2);
    note_to_load     = 6'd10;
    duration_to_load = 6'd4;
    load_new_note    = 1'b1;
    beat             = 1'b1;
    cyc(1);
    load_new_note    = 1'b0;
    beat             = 1'b0;
    cyc(1);
    check("n10_step", {12'd0, step_size}, 32'd1010);
    repeat (3) begin pulse_beat(); cyc(1); end
    check("n10_undecremented", {31'd0, note_done}, 32'd0);
    pulse_beat();
    check("n10_done", {31'd0, note_done}, 32'd1);

    // duration 0, bounded wait for the voice to free up
    load(5, 0);
    k = 0;
    while (note_done !== 1'b1 && k < 10) begin
      cyc(1);
      k++;
    end
    check("dur0_cycles_to_free", k, 32'd2);

    // last-beat articulation
    load(49, 3);
    cyc(1);
    pulse_beat(); cyc(1);
    pulse_beat(); cyc(1);
`ifdef NOTE_PLAYER_GAP_EN
    check("gap_last_beat", {12'd0, step_size}, 32'd0);
`else
    check("nogap_last_beat", {12'd0, step_size}, 32'h0258C);
`endif
    pulse_beat();
    check("gap_done", {31'd0, note_done}, 32'd1);
    load(49, 1);
    cyc(1);
    check("dur1_step", {12'd0, step_size}, 32'h0258C);
    pulse_beat();
    check("dur1_done", {31'd0, note_done}, 32'd1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      reset         = ($urandom_range(0, 599) == 0);
      load_new_note = ($urandom_range(0, 11) == 0);
      note_to_load  = 6'($urandom_range(0, 63));
      duration_to_load = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                     : 6'($urandom_range(0, 4));
      beat          = ($urandom_range(0, 2) == 0);
      play_enable   = ($urandom_range(0, 7) != 0);
      cyc(1);
    end
    reset         = 1'b0;
    load_new_note = 1'b0;
    beat          = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
